modulo_n_arbiter: RTL and testbench

- Round-robin arbiter that shares one Modulo_N counter between NREQ requesters.
- Each requester asks for a whole number of counter periods (full 0..N-1 sweeps).
- The arbiter grants the counter to one requester at a time and drives the counter's ce and rst. It watches the counter output to count wraps and signal completion.
- Sits between client blocks and a single Modulo_N instance.

---
 rtl/modulo_n_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_modulo_n_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modulo_n_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : modulo_n_arbiter
// Purpose  : Round-robin arbiter sharing one Modulo_N counter between NREQ
//            requesters. The owner gets a whole number of counter periods
//            (full 0..N-1 sweeps). The arbiter clears the counter, enables it,
//            counts wraps on cnt_y and pulses done when the last one is seen.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk      in   1           rising-edge clock
//   rst      in   1           asynchronous reset, active low
//   req      in   NREQ        request level, held until done or abandon
//   len      in   NREQ*LEN_W  period count per requester, sampled at grant
//   cnt_y    in   WIDTH       current value of the shared counter
//   cnt_ce   out  1           count enable to the counter
//   cnt_rst  out  1           synchronous clear to the counter
//   gnt      out  NREQ        one-hot grant
//   done     out  NREQ        one-cycle completion pulse
//   busy     out  1           high whenever the arbiter is not idle
// ============================================================================
module modulo_n_arbiter #(
    parameter  int N     = 5,
    parameter  int NREQ  = 4,
    parameter  int LEN_W = 4,
    localparam int WIDTH = (N > 1) ? $clog2(N) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*LEN_W-1:0] len,
    input  logic [WIDTH-1:0]      cnt_y,
    output logic                  cnt_ce,
    output logic                  cnt_rst,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic                  busy
);

    localparam int              PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [WIDTH-1:0] LAST_Y = WIDTH'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CLR  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q,   ptr_d;
    logic [PTR_W-1:0]   sel_q,   sel_d;
    logic [LEN_W-1:0]   wcnt_q,  wcnt_d;
    logic [LEN_W-1:0]   len_q,   len_d;
    logic [NREQ-1:0]    gnt_q,   gnt_d;
    logic [NREQ-1:0]    done_q,  done_d;
    logic               cnt_ce_q,  cnt_ce_d;
    logic               cnt_rst_q, cnt_rst_d;
    logic               busy_q,    busy_d;

    logic [PTR_W-1:0]   w_pick;
    logic [LEN_W-1:0]   w_pick_len;
    logic               w_wrap;

    // First requesting index strictly after the pointer, wrapping modulo NREQ.
    // The pointer itself is visited last, so the previous owner has the
    // lowest priority.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [NREQ-1:0] r,
                                                 input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(p) + i) % NREQ;
            if (!found && r[PTR_W'(idx)]) begin
                found = 1'b1;
                pick  = PTR_W'(idx);
            end
        end
        return pick;
    endfunction

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        wcnt_d    = wcnt_q;
        len_d     = len_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        cnt_ce_d  = 1'b0;
        cnt_rst_d = 1'b0;

        w_pick     = rr_pick(req, ptr_q);
        w_pick_len = len[int'(w_pick)*LEN_W +: LEN_W];
        // Only a cycle in which the counter is actually enabled can be a wrap.
        w_wrap     = cnt_ce_q && (cnt_y == LAST_Y);

        case (state_q)
            S_IDLE: begin
                gnt_d = '0;
                if (|req) begin
                    state_d        = S_CLR;
                    sel_d          = w_pick;
                    gnt_d[w_pick]  = 1'b1;
                    // A zero-length request still gets one full period.
                    len_d          = (w_pick_len == '0) ? LEN_W'(1) : w_pick_len;
                    wcnt_d         = '0;
                    cnt_rst_d      = 1'b1;
                end
            end
            S_CLR: begin
                if (!req[sel_q]) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                    ptr_d   = sel_q;
                end else begin
                    state_d  = S_RUN;
                    cnt_ce_d = 1'b1;
                end
            end
            S_RUN: begin
                // Abandon wins over a coincident final wrap: no done pulse.
                if (!req[sel_q]) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                    ptr_d   = sel_q;
                end else if (w_wrap && (wcnt_q == len_q - LEN_W'(1))) begin
                    state_d       = S_DONE;
                    gnt_d         = '0;
                    done_d[sel_q] = 1'b1;
                    ptr_d         = sel_q;
                end else begin
                    cnt_ce_d = 1'b1;
                    if (w_wrap) begin
                        wcnt_d = wcnt_q + LEN_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= PTR_W'(NREQ - 1);
            sel_q     <= '0;
            wcnt_q    <= '0;
            len_q     <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            cnt_ce_q  <= 1'b0;
            cnt_rst_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            wcnt_q    <= wcnt_d;
            len_q     <= len_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            cnt_ce_q  <= cnt_ce_d;
            cnt_rst_q <= cnt_rst_d;
            busy_q    <= busy_d;
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign cnt_ce  = cnt_ce_q;
    assign cnt_rst = cnt_rst_q;
    assign busy    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_modulo_n_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_modulo_n_arbiter
// Purpose  : Self-checking bench for modulo_n_arbiter with an attached
//            Modulo_N counter, a cycle-count reference model, directed
//            scenarios and randomized requesters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_modulo_n_arbiter;

    localparam int N     = 5;
    localparam int NREQ  = 4;
    localparam int LEN_W = 4;
    localparam int WIDTH = 3;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*LEN_W-1:0] len = '0;
    logic [WIDTH-1:0]      cnt_y = '0;
    logic                  cnt_ce, cnt_rst, busy;
    logic [NREQ-1:0]       gnt, done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    modulo_n_arbiter #(.N(N), .NREQ(NREQ), .LEN_W(LEN_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .len     (len),
        .cnt_y   (cnt_y),
        .cnt_ce  (cnt_ce),
        .cnt_rst (cnt_rst),
        .gnt     (gnt),
        .done    (done),
        .busy    (busy)
    );

    // The shared Modulo_N counter.
    always @(posedge clk) begin
        if (cnt_rst)     cnt_y <= '0;
        else if (cnt_ce) cnt_y <= (cnt_y == WIDTH'(N - 1)) ? '0 : cnt_y + 1'b1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: tracks who owns the counter and how many RUN
    // cycles have elapsed against a budget of len*N cycles.
    // ------------------------------------------------------------------
    typedef enum {M_IDLE, M_CLR, M_RUN, M_DONE} mphase_t;
    mphase_t m_ph      = M_IDLE;
    int      m_owner   = 0;
    int      m_ptr     = NREQ - 1;
    int      m_total   = 0;
    int      m_elapsed = 0;

    function automatic int rr_next(input logic [NREQ-1:0] r, input int p);
        for (int k = 1; k <= NREQ; k++)
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    function automatic int eff_len(input int i);
        int v;
        v = int'(len[i*LEN_W +: LEN_W]);
        return (v == 0) ? 1 : v;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ph      <= M_IDLE;
            m_ptr     <= NREQ - 1;
            m_owner   <= 0;
            m_total   <= 0;
            m_elapsed <= 0;
        end else begin
            case (m_ph)
                M_IDLE: if (|req) begin
                    m_owner   <= rr_next(req, m_ptr);
                    m_total   <= N * eff_len(rr_next(req, m_ptr));
                    m_elapsed <= 0;
                    m_ph      <= M_CLR;
                end
                M_CLR: if (!req[m_owner]) begin
                    m_ph  <= M_IDLE;
                    m_ptr <= m_owner;
                end else begin
                    m_ph <= M_RUN;
                end
                M_RUN: if (!req[m_owner]) begin
                    m_ph  <= M_IDLE;
                    m_ptr <= m_owner;
                end else begin
                    m_elapsed <= m_elapsed + 1;
                    if (m_elapsed + 1 == m_total) begin
                        m_ph  <= M_DONE;
                        m_ptr <= m_owner;
                    end
                end
                M_DONE: m_ph <= M_IDLE;
                default: m_ph <= M_IDLE;
            endcase
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst) begin
            check("gnt", int'(gnt), (m_ph == M_CLR || m_ph == M_RUN) ? (1 << m_owner) : 0);
            check("done", int'(done), (m_ph == M_DONE) ? (1 << m_owner) : 0);
            check("cnt_rst", int'(cnt_rst), (m_ph == M_CLR) ? 1 : 0);
            check("cnt_ce", int'(cnt_ce), (m_ph == M_RUN) ? 1 : 0);
            check("busy", int'(busy), (m_ph != M_IDLE) ? 1 : 0);
            if (m_ph == M_RUN)  check("cnt_y_run", int'(cnt_y), m_elapsed % N);
            if (m_ph == M_DONE) check("cnt_y_done", int'(cnt_y), 0);
        end
    end

    // ------------------------------------------------------------------
    // Directed helpers
    // ------------------------------------------------------------------
    function automatic int oh2i(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic wait_idle();
        for (int c = 0; c < 200 && busy; c++) @(negedge clk);
        check("wait_idle", int'(busy), 0);
    endtask

    task automatic run_single(input int r, input int l, output int g, output int ce,
                              output int cr, output int dn, output int ybad,
                              output int busy_after);
        g = 0; ce = 0; cr = 0; dn = 0; ybad = 0; busy_after = 1;
        len[r*LEN_W +: LEN_W] = LEN_W'(l);
        req[r] = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (gnt[r])  g++;
            if (cnt_rst) cr++;
            if (cnt_ce) begin
                if (int'(cnt_y) != ce % N) ybad++;
                ce++;
            end
            if (done[r]) begin
                dn++;
                req[r] = 1'b0;
                @(negedge clk);
                busy_after = int'(busy);
                break;
            end
        end
    endtask

    int              order[$];
    int              exp_order[5] = '{0, 1, 2, 3, 0};
    logic [NREQ-1:0] prev_g;
    int              glen, ended, dn_cnt, runs;
    int              g, ce, cr, dn, ybad, ba;

    initial begin
        // Reset with every requester asking.
        rst = 1'b0;
        req = '1;
        len = {NREQ{LEN_W'(1)}};
        repeat (3) @(negedge clk);
        check("rst_gnt", int'(gnt), 0);
        check("rst_cnt_ce", int'(cnt_ce), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b1;
        @(negedge clk);
        check("first_gnt", int'(gnt), 1);

        // Round-robin with all requests held: order 0,1,2,3,0.
        prev_g = '0; glen = 0; ended = 0; dn_cnt = 0;
        for (int c = 0; c < 200 && ended < 5; c++) begin
            if (|done) dn_cnt++;
            if (gnt != '0) begin
                if (gnt != prev_g) begin
                    order.push_back(oh2i(gnt));
                    glen = 0;
                end
                glen++;
            end else if (prev_g != '0) begin
                check("rr_grant_len", glen, 6);
                ended++;
            end
            prev_g = gnt;
            if (ended < 5) @(negedge clk);
        end
        req = '0;
        check("rr_grants", order.size(), 5);
        check("rr_dones", dn_cnt, 5);
        for (int i = 0; i < 5 && i < order.size(); i++) check("rr_order", order[i], exp_order[i]);
        wait_idle();

        // Single request, two periods.
        run_single(0, 2, g, ce, cr, dn, ybad, ba);
        check("single_gnt_cycles", g, 11);
        check("single_run_cycles", ce, 10);
        check("single_clr_cycles", cr, 1);
        check("single_done", dn, 1);
        check("single_cnt_y_seq", ybad, 0);
        check("single_busy_after", ba, 0);

        // Zero length behaves as one period.
        run_single(2, 0, g, ce, cr, dn, ybad, ba);
        check("zero_gnt_cycles", g, 6);
        check("zero_run_cycles", ce, 5);
        check("zero_done", dn, 1);

        // Maximum length.
        run_single(3, 15, g, ce, cr, dn, ybad, ba);
        check("max_run_cycles", ce, 75);
        check("max_cnt_y_seq", ybad, 0);

        // Abandon after 7 RUN cycles; pending requester 3 then takes over.
        len[1*LEN_W +: LEN_W] = LEN_W'(3);
        len[3*LEN_W +: LEN_W] = LEN_W'(1);
        req[1] = 1'b1;
        for (int c = 0; c < 20 && !gnt[1]; c++) @(negedge clk);
        check("abn_gnt1", int'(gnt[1]), 1);
        req[3] = 1'b1;
        runs = 0;
        for (int c = 0; c < 50 && runs < 7; c++) begin
            @(negedge clk);
            if (cnt_ce && gnt[1]) runs++;
        end
        req[1] = 1'b0;
        @(negedge clk);
        check("abn_gnt_off", int'(gnt), 0);
        check("abn_ce_off", int'(cnt_ce), 0);
        check("abn_no_done", int'(done), 0);
        check("abn_cnt_left", int'(cnt_y), 2);
        @(negedge clk);
        check("abn_next_gnt", int'(gnt), 8);
        check("abn_next_clr", int'(cnt_rst), 1);
        @(negedge clk);
        check("abn_cleared", int'(cnt_y), 0);
        check("abn_counting", int'(cnt_ce), 1);
        for (int c = 0; c < 20 && !done[3]; c++) @(negedge clk);
        check("abn_done3", int'(done[3]), 1);
        req[3] = 1'b0;
        wait_idle();

        // Move the pointer to 1 so the post-reset grant proves it was reset.
        run_single(1, 1, g, ce, cr, dn, ybad, ba);
        check("ptr_move_done", dn, 1);

        // Asynchronous reset in the middle of RUN.
        len[2*LEN_W +: LEN_W] = LEN_W'(2);
        req[2] = 1'b1;
        for (int c = 0; c < 50 && !(cnt_ce && cnt_y == 3); c++) @(negedge clk);
        check("arst_at_y3", int'(cnt_y), 3);
        #2 rst = 1'b0;
        #1;
        check("arst_gnt", int'(gnt), 0);
        check("arst_cnt_ce", int'(cnt_ce), 0);
        check("arst_busy", int'(busy), 0);
        @(negedge clk);
        req = '1;
        len = {NREQ{LEN_W'(1)}};
        rst = 1'b1;
        @(negedge clk);
        check("arst_restart_gnt", int'(gnt), 1);
        req = '0;
        wait_idle();

        // Randomized requesters, checked cycle by cycle against the model.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (req[i]) begin
                    if (done[i])                         req[i] = 1'b0;
                    else if ($urandom_range(0, 199) == 0) req[i] = 1'b0;
                    if ($urandom_range(0, 7) == 0) len[i*LEN_W +: LEN_W] = LEN_W'($urandom);
                end else if ($urandom_range(0, 5) == 0) begin
                    len[i*LEN_W +: LEN_W] = LEN_W'($urandom);
                    req[i] = 1'b1;
                end
            end
            if ($urandom_range(0, 999) == 0) begin
                #2 rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
            end
        end
        req = '0;
        wait_idle();
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
